// File: rtl/scs8hd_pipe_pkg.sv
// Shared constants and parameter legality check for the scs8hd registered nor2b bank.
package scs8hd_pipe_pkg;

  localparam int MODE_NOR2  = 0;
  localparam int MODE_NOR2B = 1;
  localparam int MAX_WIDTH  = 32;
  localparam int MAX_STAGES = 8;

  function automatic bit params_legal(input int width, input int stages, input int mode);
    return (width >= 1) && (width <= MAX_WIDTH) &&
           (stages >= 1) && (stages <= MAX_STAGES) &&
           ((mode == MODE_NOR2) || (mode == MODE_NOR2B));
  endfunction

endpackage

// File: rtl/scs8hd_nor2b_pipe_stage.sv
// One pipeline stage: WIDTH data flops with enable hold and mux-D scan, plus a valid flop.
module scs8hd_nor2b_pipe_stage #(
  parameter int WIDTH = 4
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             de_i,
  input  logic             sce_i,
  input  logic             scan_i,
  input  logic             valid_i,
  input  logic [WIDTH-1:0] data_i,
  output logic [WIDTH-1:0] data_o,
  output logic             valid_o,
  output logic             scan_o
);

  logic [WIDTH-1:0] data_q, data_d;
  logic             valid_q, valid_d;

  // Ternary muxes so an unknown SCE/DE merges into the flops rather than picking a branch.
  assign data_d  = sce_i ? ((data_q << 1) | WIDTH'(scan_i))
                         : (de_i ? data_i : data_q);
  assign valid_d = sce_i ? valid_q : (de_i ? valid_i : valid_q);

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      data_q  <= '0;
      valid_q <= 1'b0;
    end else begin
      data_q  <= data_d;
      valid_q <= valid_d;
    end
  end

  assign data_o  = data_q;
  assign valid_o = valid_q;
  assign scan_o  = data_q[WIDTH-1];

endmodule

// File: rtl/scs8hd_nor2b_pipe.sv
// Registered, scan-testable bank of WIDTH nor2b/nor2 gates behind a STAGES-deep pipeline.
module scs8hd_nor2b_pipe
  import scs8hd_pipe_pkg::*;
#(
  parameter int WIDTH  = 4,
  parameter int STAGES = 2,
  parameter int MODE   = 1
) (
`ifdef SC_USE_PG_PIN
  input  logic             vpwr,
  input  logic             vgnd,
  input  logic             vpb,
  input  logic             vnb,
`endif
  input  logic             CLK,
  input  logic             RESETB,
  input  logic             DE,
  input  logic             SCE,
  input  logic             SCD,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] BN,
  output logic [WIDTH-1:0] Y,
  output logic             Q_VALID,
  output logic             SCQ
);

  if (!params_legal(WIDTH, STAGES, MODE)) begin : g_illegal
    $error("scs8hd_nor2b_pipe: illegal WIDTH/STAGES/MODE");
  end

  logic [WIDTH-1:0]             func_w;
  logic [STAGES:0][WIDTH-1:0]   data_w;
  logic [STAGES:0]              valid_w;
  logic [STAGES:0]              scan_w;
  logic [WIDTH-1:0]             y_int;
  logic                         qv_int;
  logic                         scq_int;

  assign func_w     = (MODE == MODE_NOR2B) ? (~A & BN) : ~(A | BN);
  assign data_w[0]  = func_w;
  assign valid_w[0] = 1'b1;
  assign scan_w[0]  = SCD;

  // Stage gi feeds stage gi+1 on both the data path and the scan chain.
  for (genvar gi = 0; gi < STAGES; gi++) begin : g_stage
    scs8hd_nor2b_pipe_stage #(.WIDTH(WIDTH)) u_stage (
      .clk_i   (CLK),
      .rst_ni  (RESETB),
      .de_i    (DE),
      .sce_i   (SCE),
      .scan_i  (scan_w[gi]),
      .valid_i (valid_w[gi]),
      .data_i  (data_w[gi]),
      .data_o  (data_w[gi+1]),
      .valid_o (valid_w[gi+1]),
      .scan_o  (scan_w[gi+1])
    );
  end

  assign y_int   = data_w[STAGES];
  assign qv_int  = valid_w[STAGES];
  assign scq_int = scan_w[STAGES];

`ifdef SC_USE_PG_PIN
  // Bad supply forces every output bit to X; the flops keep their contents.
  for (genvar gi = 0; gi < WIDTH; gi++) begin : g_pg_y
    scs8hd_pg_U_VPWR_VGND u_pg_y (Y[gi], y_int[gi], vpwr, vgnd);
  end
  scs8hd_pg_U_VPWR_VGND u_pg_qv  (Q_VALID, qv_int, vpwr, vgnd);
  scs8hd_pg_U_VPWR_VGND u_pg_scq (SCQ, scq_int, vpwr, vgnd);
`else
  assign Y       = y_int;
  assign Q_VALID = qv_int;
  assign SCQ     = scq_int;
`endif

`ifndef functional
`ifndef SC_USE_PG_PIN
  supply1 vpwr;
  supply0 vgnd;
  supply1 vpb;
  supply0 vnb;
`endif
  reg notifier;
  specify
    (CLK *> Y)         = (0, 0);
    (CLK *> Q_VALID)   = (0, 0);
    (CLK *> SCQ)       = (0, 0);
    (RESETB *> Y)       = (0, 0);
    (RESETB *> Q_VALID) = (0, 0);
    (RESETB *> SCQ)     = (0, 0);
    $setuphold(posedge CLK, A,   0, 0, notifier);
    $setuphold(posedge CLK, BN,  0, 0, notifier);
    $setuphold(posedge CLK, DE,  0, 0, notifier);
    $setuphold(posedge CLK, SCE, 0, 0, notifier);
    $setuphold(posedge CLK, SCD, 0, 0, notifier);
    $recrem(posedge RESETB, posedge CLK, 0, 0, notifier);
  endspecify
`endif

endmodule

// File: tb/tb_scs8hd_nor2b_pipe.sv
// Randomised self-checking bench: four configurations against a flat scan-chain reference model.
module tb_scs8hd_nor2b_pipe;

  localparam int NDUT = 4;

  logic        clk = 1'b0;
  logic        rstb, de, sce, scd;
  logic [31:0] a_in, bn_in;
  logic [3:0]  y0, y1;
  logic [0:0]  y2;
  logic [31:0] y3;
  logic [NDUT-1:0] qv, scq;

  always #5 clk = ~clk;

  scs8hd_nor2b_pipe #(.WIDTH(4), .STAGES(2), .MODE(1)) u_dut0 (
    .CLK(clk), .RESETB(rstb), .DE(de), .SCE(sce), .SCD(scd),
    .A(a_in[3:0]), .BN(bn_in[3:0]), .Y(y0), .Q_VALID(qv[0]), .SCQ(scq[0]));
  scs8hd_nor2b_pipe #(.WIDTH(4), .STAGES(2), .MODE(0)) u_dut1 (
    .CLK(clk), .RESETB(rstb), .DE(de), .SCE(sce), .SCD(scd),
    .A(a_in[3:0]), .BN(bn_in[3:0]), .Y(y1), .Q_VALID(qv[1]), .SCQ(scq[1]));
  scs8hd_nor2b_pipe #(.WIDTH(1), .STAGES(1), .MODE(1)) u_dut2 (
    .CLK(clk), .RESETB(rstb), .DE(de), .SCE(sce), .SCD(scd),
    .A(a_in[0:0]), .BN(bn_in[0:0]), .Y(y2), .Q_VALID(qv[2]), .SCQ(scq[2]));
  scs8hd_nor2b_pipe #(.WIDTH(32), .STAGES(8), .MODE(1)) u_dut3 (
    .CLK(clk), .RESETB(rstb), .DE(de), .SCE(sce), .SCD(scd),
    .A(a_in), .BN(bn_in), .Y(y3), .Q_VALID(qv[3]), .SCQ(scq[3]));

  int n_checks = 0;
  int n_fail   = 0;
  int txn      = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Reference model: each pipeline is one flat bit vector in scan-chain order.
  logic [255:0] m_chain [NDUT];
  int           m_cnt   [NDUT];

  function automatic int dw(input int i);
    case (i)
      0, 1:    return 4;
      2:       return 1;
      default: return 32;
    endcase
  endfunction

  function automatic int ds(input int i);
    case (i)
      0, 1:    return 2;
      2:       return 1;
      default: return 8;
    endcase
  endfunction

  function automatic logic [31:0] wmask(input int i);
    logic [31:0] m;
    m = '1;
    return m >> (32 - dw(i));
  endfunction

  function automatic logic [255:0] cmask(input int i);
    logic [255:0] m;
    m = '1;
    return m >> (256 - dw(i) * ds(i));
  endfunction

  function automatic logic [31:0] fval(input int i);
    logic [31:0] r;
    r = (i == 1) ? ~(a_in | bn_in) : (~a_in & bn_in);
    return r & wmask(i);
  endfunction

  function automatic logic [31:0] exp_y(input int i);
    logic [255:0] t;
    t = m_chain[i] >> (dw(i) * (ds(i) - 1));
    return t[31:0] & wmask(i);
  endfunction

  function automatic logic [31:0] exp_scq(input int i);
    logic [255:0] t;
    t = m_chain[i] >> (dw(i) * ds(i) - 1);
    return {31'b0, t[0]};
  endfunction

  function automatic logic [31:0] y_obs(input int i);
    case (i)
      0:       return {28'b0, y0};
      1:       return {28'b0, y1};
      2:       return {31'b0, y2};
      default: return y3;
    endcase
  endfunction

  task automatic model_reset();
    for (int i = 0; i < NDUT; i++) begin
      m_chain[i] = '0;
      m_cnt[i]   = 0;
    end
  endtask

  task automatic model_edge();
    for (int i = 0; i < NDUT; i++) begin
      if (!rstb) begin
        m_chain[i] = '0;
        m_cnt[i]   = 0;
      end else if (sce) begin
        m_chain[i] = ((m_chain[i] << 1) | 256'(scd)) & cmask(i);
      end else if (de) begin
        m_chain[i] = ((m_chain[i] << dw(i)) | 256'(fval(i))) & cmask(i);
        if (m_cnt[i] < ds(i)) m_cnt[i]++;
      end
    end
  endtask

  task automatic check_all(input string ph);
    for (int i = 0; i < NDUT; i++) begin
      check_eq($sformatf("%s.y%0d", ph, i), y_obs(i), exp_y(i));
      check_eq($sformatf("%s.qv%0d", ph, i), {31'b0, qv[i]}, {31'b0, m_cnt[i] >= ds(i)});
      check_eq($sformatf("%s.scq%0d", ph, i), {31'b0, scq[i]}, exp_scq(i));
    end
  endtask

  task automatic tick();
    model_edge();
    @(posedge clk);
    #1;
    txn++;
    $display("txn %0d rstb=%b de=%b sce=%b scd=%b y0=%h y1=%h y2=%h y3=%h qv=%b scq=%b",
             txn, rstb, de, sce, scd, y0, y1, y2, y3, qv, scq);
    check_all("cyc");
  endtask

  // Called one time unit after an edge; drops reset between edges and checks outputs clear.
  task automatic async_reset();
    #2;
    rstb = 1'b0;
    #1;
    model_reset();
    check_all("arst");
    rstb = 1'b1;
  endtask

  logic [7:0] pat;

  initial begin
    rstb  = 1'b0;
    de    = 1'b1;
    sce   = 1'b0;
    scd   = 1'b0;
    a_in  = $urandom;
    bn_in = $urandom;
    model_reset();

    repeat (3) begin
      a_in  = $urandom;
      bn_in = $urandom;
      tick();
    end
    check_eq("rst_y3", y3, 32'h0);
    rstb = 1'b1;

    a_in  = 32'h3;
    bn_in = 32'h5;
    tick();
    tick();
    check_eq("nor2b_y", {28'b0, y0}, 32'h4);
    check_eq("nor2_y", {28'b0, y1}, 32'h8);
    check_eq("qv_s2", {31'b0, qv[0]}, 32'h1);

    a_in  = 32'h0;
    bn_in = 32'hA;
    tick();
    tick();
    de    = 1'b0;
    bn_in = 32'h5;
    repeat (3) begin
      tick();
      check_eq("stall_hold", {28'b0, y0}, 32'hA);
    end
    de = 1'b1;
    tick();
    tick();
    check_eq("stall_rel", {28'b0, y0}, 32'h5);

    pat = 8'b10110010;
    sce = 1'b1;
    de  = 1'b1;
    for (int k = 0; k < 8; k++) begin
      scd = pat[7-k];
      tick();
    end
    scd = 1'b0;
    for (int j = 0; j < 8; j++) begin
      check_eq("scan_out", {31'b0, scq[0]}, {31'b0, pat[7-j]});
      tick();
    end
    check_eq("scan_qv", {31'b0, qv[0]}, 32'h1);
    sce = 1'b0;

    async_reset();
    de = 1'b1;
    for (int k = 1; k <= 8; k++) begin
      a_in  = $urandom;
      bn_in = $urandom;
      tick();
      check_eq("qv_ramp8", {31'b0, qv[3]}, {31'b0, k >= 8});
    end

    sce = 1'b1;
    scd = 1'b1;
    tick();
    scd = 1'b0;
    repeat (255) tick();
    check_eq("chain256", {31'b0, scq[3]}, 32'h1);
    tick();
    check_eq("chain257", {31'b0, scq[3]}, 32'h0);
    sce = 1'b0;

    for (int n = 0; n < 300; n++) begin
      de    = ($urandom_range(0, 3) != 0);
      sce   = ($urandom_range(0, 7) == 0);
      scd   = 1'($urandom);
      a_in  = $urandom;
      bn_in = $urandom;
      if ($urandom_range(0, 49) == 0) async_reset();
      tick();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
